// File: rtl/pa_wb_pkg.sv
// Shared types and constants for the writeback arbiter: producer numbering,
// register/data widths and the queued writeback entry.
package pa_wb_pkg;

  localparam int NUM_PRODUCERS = 4;
  localparam int REG_ADDR_W    = 5;
  localparam int DATA_W        = 16;

  localparam int PROD_ARITH_A  = 0;
  localparam int PROD_ARITH_B  = 1;
  localparam int PROD_LS_A     = 2;
  localparam int PROD_LS_B     = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // Round-robin scan position; the 2-bit add wraps modulo the producer count.
  function automatic logic [1:0] rr_index(input logic [1:0] base, input logic [1:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/pa_wb_fifo.sv
// Single-producer writeback FIFO. Pointers wrap at DEPTH; the count carries one
// extra bit so full and empty are distinguishable.
module pa_wb_fifo
  import pa_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      push_i,
  input  wb_entry_t entry_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = entry_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // A simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pa_writeback_arbiter.sv
// Four producer FIFOs drained round-robin onto two register-file write ports,
// never writing one address twice per cycle. Define WB_PERF_EN for perf counters.
module pa_writeback_arbiter
  import pa_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic [NUM_PRODUCERS-1:0]            req_valid_i,
  input  logic [NUM_PRODUCERS*REG_ADDR_W-1:0] req_addr_i,
  input  logic [NUM_PRODUCERS*DATA_W-1:0]     req_data_i,
  output logic [NUM_PRODUCERS-1:0]            req_ready_o,
  output logic                                wbA_o,
  output logic [REG_ADDR_W-1:0]               wbAddrA_o,
  output logic [DATA_W-1:0]                   wbValA_o,
  output logic                                wbB_o,
  output logic [REG_ADDR_W-1:0]               wbAddrB_o,
  output logic [DATA_W-1:0]                   wbValB_o,
  output logic                                stall_o,
  output logic                                overflow_o
`ifdef WB_PERF_EN
  ,
  output logic [31:0]                         grant_count_o,
  output logic [15:0]                         conflict_count_o
`endif
);

  wb_entry_t                  req_entry [NUM_PRODUCERS];
  wb_entry_t                  head      [NUM_PRODUCERS];
  logic [NUM_PRODUCERS-1:0]   full, empty, push, pop;

  logic [1:0]                 ptr_q, ptr_d, idx, idx_a, idx_b;
  logic                       grant_a, grant_b, conflict;
  logic                       wb_a_q, wb_a_d, wb_b_q, wb_b_d;
  logic [REG_ADDR_W-1:0]      addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_W-1:0]          val_a_q, val_a_d, val_b_q, val_b_d;
  logic                       overflow_q, overflow_d;

  assign req_ready_o = ~full;
  assign push        = req_valid_i & ~full;
  assign stall_o     = |full;

  for (genvar g = 0; g < NUM_PRODUCERS; g++) begin : g_fifo
    assign req_entry[g] = {req_addr_i[g*REG_ADDR_W +: REG_ADDR_W], req_data_i[g*DATA_W +: DATA_W]};

    pa_wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .push_i  (push[g]),
      .entry_i (req_entry[g]),
      .pop_i   (pop[g]),
      .head_o  (head[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  // Port B takes the next head after port A whose address differs from A's.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    idx_a    = '0;
    idx_b    = '0;
    idx      = '0;
    conflict = 1'b0;
    for (int i = 0; i < NUM_PRODUCERS; i++) begin
      idx = rr_index(ptr_q, 2'(i));
      if (!empty[idx]) begin
        if (!grant_a) begin
          grant_a = 1'b1;
          idx_a   = idx;
        end else if (!grant_b) begin
          if (head[idx].addr != head[idx_a].addr) begin
            grant_b = 1'b1;
            idx_b   = idx;
          end else begin
            conflict = 1'b1;
          end
        end
      end
    end

    pop = '0;
    if (grant_a) pop[idx_a] = 1'b1;
    if (grant_b) pop[idx_b] = 1'b1;

    ptr_d = ptr_q;
    if (grant_b)      ptr_d = idx_b + 2'd1;
    else if (grant_a) ptr_d = idx_a + 2'd1;
  end

  always_comb begin
    wb_a_d     = grant_a;
    wb_b_d     = grant_b;
    addr_a_d   = grant_a ? head[idx_a].addr : addr_a_q;
    val_a_d    = grant_a ? head[idx_a].data : val_a_q;
    addr_b_d   = grant_b ? head[idx_b].addr : addr_b_q;
    val_b_d    = grant_b ? head[idx_b].data : val_b_q;
    overflow_d = overflow_q | (|(req_valid_i & full));
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ptr_q      <= '0;
      wb_a_q     <= 1'b0;
      wb_b_q     <= 1'b0;
      addr_a_q   <= '0;
      val_a_q    <= '0;
      addr_b_q   <= '0;
      val_b_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      wb_a_q     <= wb_a_d;
      wb_b_q     <= wb_b_d;
      addr_a_q   <= addr_a_d;
      val_a_q    <= val_a_d;
      addr_b_q   <= addr_b_d;
      val_b_q    <= val_b_d;
      overflow_q <= overflow_d;
    end
  end

  assign wbA_o      = wb_a_q;
  assign wbAddrA_o  = addr_a_q;
  assign wbValA_o   = val_a_q;
  assign wbB_o      = wb_b_q;
  assign wbAddrB_o  = addr_b_q;
  assign wbValB_o   = val_b_q;
  assign overflow_o = overflow_q;

`ifdef WB_PERF_EN
  logic [31:0] grant_count_q, grant_count_d;
  logic [15:0] conflict_count_q, conflict_count_d;
  logic [32:0] grant_sum;

  // Both counters stick at their maximum instead of wrapping.
  always_comb begin
    grant_sum        = {1'b0, grant_count_q} + 33'(grant_a) + 33'(grant_b);
    grant_count_d    = grant_sum[32] ? '1 : grant_sum[31:0];
    conflict_count_d = conflict_count_q;
    if (conflict && (conflict_count_q != '1)) begin
      conflict_count_d = conflict_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      grant_count_q    <= '0;
      conflict_count_q <= '0;
    end else begin
      grant_count_q    <= grant_count_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign grant_count_o    = grant_count_q;
  assign conflict_count_o = conflict_count_q;
`endif

endmodule

// File: tb/tb_pa_writeback_arbiter.sv
// Randomised bench for pa_writeback_arbiter: a queue-based reference model feeds
// a scoreboard of expected port writes that a negedge monitor drains and checks.
module tb_pa_writeback_arbiter;
  import pa_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  req_valid_i = '0;
  logic [19:0] req_addr_i = '0;
  logic [63:0] req_data_i = '0;
  logic [3:0]  req_ready_o;
  logic        wbA_o, wbB_o, stall_o, overflow_o;
  logic [4:0]  wbAddrA_o, wbAddrB_o;
  logic [15:0] wbValA_o, wbValB_o;
`ifdef WB_PERF_EN
  logic [31:0] grant_count_o;
  logic [15:0] conflict_count_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock_i = ~clock_i;

  pa_writeback_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .wbA_o       (wbA_o),
    .wbAddrA_o   (wbAddrA_o),
    .wbValA_o    (wbValA_o),
    .wbB_o       (wbB_o),
    .wbAddrB_o   (wbAddrB_o),
    .wbValB_o    (wbValB_o),
    .stall_o     (stall_o),
    .overflow_o  (overflow_o)
`ifdef WB_PERF_EN
    ,
    .grant_count_o    (grant_count_o),
    .conflict_count_o (conflict_count_o)
`endif
  );

  // Reference state: one queue per producer, the scan start, sticky overflow,
  // the last value latched on each port, and the writes due on each port.
  wb_entry_t mq [NUM_PRODUCERS][$];
  int        m_ptr = 0;
  bit        m_ovf = 1'b0;
  wb_entry_t hold_a = '0, hold_b = '0;
  wb_entry_t exp_a [$];
  wb_entry_t exp_b [$];

  always @(posedge clock_i) begin : ref_model
    int        n, na, nb;
    bit        ga, gb;
    bit [3:0]  rdy;
    wb_entry_t e;
    if (reset_i) begin
      for (int p = 0; p < NUM_PRODUCERS; p++) mq[p].delete();
      m_ptr  = 0;
      m_ovf  = 1'b0;
      hold_a = '0;
      hold_b = '0;
      exp_a.delete();
      exp_b.delete();
    end else begin
      for (int p = 0; p < NUM_PRODUCERS; p++) rdy[p] = (mq[p].size() < DEPTH);
      if ((req_valid_i & ~rdy) != 4'b0) m_ovf = 1'b1;
      ga = 1'b0; gb = 1'b0; na = 0; nb = 0;
      for (int i = 0; i < NUM_PRODUCERS; i++) begin
        n = (m_ptr + i) % NUM_PRODUCERS;
        if (mq[n].size() != 0) begin
          if (!ga) begin
            ga = 1'b1; na = n;
          end else if (!gb && mq[n][0].addr != mq[na][0].addr) begin
            gb = 1'b1; nb = n;
          end
        end
      end
      if (ga) begin
        e = mq[na].pop_front();
        exp_a.push_back(e);
        hold_a = e;
      end
      if (gb) begin
        e = mq[nb].pop_front();
        exp_b.push_back(e);
        hold_b = e;
      end
      if (gb)      m_ptr = (nb + 1) % NUM_PRODUCERS;
      else if (ga) m_ptr = (na + 1) % NUM_PRODUCERS;
      for (int p = 0; p < NUM_PRODUCERS; p++) begin
        if (req_valid_i[p] && rdy[p]) begin
          e.addr = req_addr_i[p*5 +: 5];
          e.data = req_data_i[p*16 +: 16];
          mq[p].push_back(e);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock_i) begin : monitor
    logic [3:0] er;
    bit         es;
    wb_entry_t  ea, eb;
    bit         pa, pb;
    es = 1'b0;
    for (int p = 0; p < NUM_PRODUCERS; p++) begin
      er[p] = (mq[p].size() < DEPTH);
      if (mq[p].size() == DEPTH) es = 1'b1;
    end
    checkOutput("req_ready", 32'(req_ready_o), 32'(er));
    checkOutput("stall", 32'(stall_o), 32'(es));
    checkOutput("overflow", 32'(overflow_o), 32'(m_ovf));
    pa = (exp_a.size() != 0);
    pb = (exp_b.size() != 0);
    ea = pa ? exp_a.pop_front() : hold_a;
    eb = pb ? exp_b.pop_front() : hold_b;
    checkOutput("wbA_en", 32'(wbA_o), 32'(pa));
    checkOutput("wbA_addr", 32'(wbAddrA_o), 32'(ea.addr));
    checkOutput("wbA_val", 32'(wbValA_o), 32'(ea.data));
    checkOutput("wbB_en", 32'(wbB_o), 32'(pb));
    checkOutput("wbB_addr", 32'(wbAddrB_o), 32'(eb.addr));
    checkOutput("wbB_val", 32'(wbValB_o), 32'(eb.data));
  end

  task automatic applyStimulus(input logic rst, input logic [3:0] v,
                               input logic [19:0] a, input logic [63:0] d);
    @(posedge clock_i);
    #1;
    reset_i     = rst;
    req_valid_i = v;
    req_addr_i  = a;
    req_data_i  = d;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) applyStimulus(1'b0, 4'b0, '0, '0);
  endtask

  task automatic randomTraffic(input int cycles, input int max_addr);
    logic [3:0]  v;
    logic [19:0] a;
    logic [63:0] d;
    for (int c = 0; c < cycles; c++) begin
      v = 4'($urandom_range(0, 15));
      for (int p = 0; p < NUM_PRODUCERS; p++) begin
        a[p*5 +: 5]   = 5'($urandom_range(0, max_addr));
        d[p*16 +: 16] = 16'($urandom);
      end
      applyStimulus(1'b0, v, a, d);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 4'b0, '0, '0);
    applyStimulus(1'b1, 4'b0, '0, '0);
    idle(10);

    applyStimulus(1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {48'd0, 16'h1234});
    idle(4);

    applyStimulus(1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
                  {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    idle(4);

    applyStimulus(1'b0, 4'b0111, {5'd0, 5'd5, 5'd6, 5'd5},
                  {16'h0000, 16'h0002, 16'h0003, 16'h0001});
    idle(4);

    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 4'b1111, {5'd9, 5'd9, 5'd9, 5'd9},
                    {16'(c), 16'(c + 16'h100), 16'(c + 16'h200), 16'(c + 16'h300)});
    end
    idle(24);

    randomTraffic(300, 7);
    idle(24);

    applyStimulus(1'b1, 4'b0, '0, '0);
    idle(4);
    applyStimulus(1'b0, 4'b1111, {5'd10, 5'd11, 5'd12, 5'd13},
                  {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD});
    applyStimulus(1'b0, 4'b0000, '0, '0);
    applyStimulus(1'b1, 4'b0000, '0, '0);
    idle(12);

    randomTraffic(200, 3);
    randomTraffic(200, 31);
    idle(30);

    @(posedge clock_i);
    #1;
    checkOutput("drain_a", 32'(exp_a.size()), 32'd0);
    checkOutput("drain_b", 32'(exp_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
